clock_setter: RTL and testbench

CLOCK_SETTER -- requirements
Module: clock_setter

---
 rtl/clock_pkg.sv | 31 +++
 rtl/mod_step.sv | 27 ++
 rtl/clock_setter.sv | 148 ++++++++++++++
 tb/tb_clock_setter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared constants, state encoding and field codes for the clock setter.
// Holds field limits and the helper used to clamp captured inputs.
package clock_pkg;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] HOUR_MAX = 6'd23;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SET_HOUR = 3'd1,
    SET_MIN  = 3'd2,
    SET_SEC  = 3'd3,
    COMMIT_H = 3'd4,
    COMMIT_M = 3'd5,
    COMMIT_S = 3'd6
  } state_t;

  localparam logic [1:0] FLD_NONE = 2'd0;
  localparam logic [1:0] FLD_HOUR = 2'd1;
  localparam logic [1:0] FLD_MIN  = 2'd2;
  localparam logic [1:0] FLD_SEC  = 2'd3;

  function automatic logic [5:0] clamp(
    input logic [5:0] v,
    input logic [5:0] max
  );
    return (v > max) ? 6'd0 : v;
  endfunction

endpackage

// File: rtl/mod_step.sv
// Combinational wrap-around up/down step of a field value.
// Ports: value/max in, inc/dec in, next out; inc+dec together holds.
module mod_step (
  input  logic [5:0] value,
  input  logic [5:0] max,
  input  logic       inc,
  input  logic       dec,
  output logic [5:0] next
);

  logic w_up;
  logic w_dn;

  assign w_up = inc & ~dec;
  assign w_dn = dec & ~inc;

  always_comb begin
    next = value;
    unique case (1'b1)
      w_up:    next = (value >= max) ? 6'd0 : value + 6'd1;
      w_dn:    next = (value == 6'd0 || value > max)
                      ? max : value - 6'd1;
      default: next = value;
    endcase
  end

endmodule

// File: rtl/clock_setter.sv
// Interactive time-setting FSM: edits shadow hour/min/sec, then loads them.
// Ports: clock/reset, btn_* pulses, cur_* live time, data/load/enable/busy/field.
module clock_setter
  import clock_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_cancel,
  input  logic [5:0] cur_sec,
  input  logic [5:0] cur_min,
  input  logic [4:0] cur_hour,
  output logic [5:0] data1,
  output logic [5:0] data2,
  output logic [5:0] data3,
  output logic       load1,
  output logic       load2,
  output logic       load3,
  output logic       enable,
  output logic       busy,
  output logic [1:0] field
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_sec;
  logic [5:0] r_min;
  logic [5:0] r_hour;

  logic       w_act;
  logic       w_capture;
  logic       w_h_inc;
  logic       w_h_dec;
  logic       w_m_inc;
  logic       w_m_dec;
  logic       w_s_inc;
  logic       w_s_dec;
  logic [5:0] w_hour_nxt;
  logic [5:0] w_min_nxt;
  logic [5:0] w_sec_nxt;

  // inc/dec only act when neither mode nor cancel is pressed
  assign w_act     = ~btn_mode & ~btn_cancel;
  assign w_capture = (r_state == IDLE) & btn_mode;

  assign w_h_inc = btn_inc & w_act & (r_state == SET_HOUR);
  assign w_h_dec = btn_dec & w_act & (r_state == SET_HOUR);
  assign w_m_inc = btn_inc & w_act & (r_state == SET_MIN);
  assign w_m_dec = btn_dec & w_act & (r_state == SET_MIN);
  assign w_s_inc = btn_inc & w_act & (r_state == SET_SEC);
  assign w_s_dec = btn_dec & w_act & (r_state == SET_SEC);

  mod_step u_hour (
    .value (r_hour),
    .max   (HOUR_MAX),
    .inc   (w_h_inc),
    .dec   (w_h_dec),
    .next  (w_hour_nxt)
  );

  mod_step u_min (
    .value (r_min),
    .max   (MIN_MAX),
    .inc   (w_m_inc),
    .dec   (w_m_dec),
    .next  (w_min_nxt)
  );

  mod_step u_sec (
    .value (r_sec),
    .max   (SEC_MAX),
    .inc   (w_s_inc),
    .dec   (w_s_dec),
    .next  (w_sec_nxt)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_hour  <= 6'd0;
      r_min   <= 6'd0;
      r_sec   <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_hour <= clamp({1'b0, cur_hour}, HOUR_MAX);
        r_min  <= clamp(cur_min, MIN_MAX);
        r_sec  <= clamp(cur_sec, SEC_MAX);
      end else begin
        r_hour <= w_hour_nxt;
        r_min  <= w_min_nxt;
        r_sec  <= w_sec_nxt;
      end
    end
  end

  // cancel takes priority over mode in every SET_* state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (btn_mode) w_state_nxt = SET_HOUR;
      end
      SET_HOUR: begin
        if (btn_cancel)    w_state_nxt = IDLE;
        else if (btn_mode) w_state_nxt = SET_MIN;
      end
      SET_MIN: begin
        if (btn_cancel)    w_state_nxt = IDLE;
        else if (btn_mode) w_state_nxt = SET_SEC;
      end
      SET_SEC: begin
        if (btn_cancel)    w_state_nxt = IDLE;
        else if (btn_mode) w_state_nxt = COMMIT_H;
      end
      COMMIT_H: w_state_nxt = COMMIT_M;
      COMMIT_M: w_state_nxt = COMMIT_S;
      COMMIT_S: w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load1  = 1'b0;
    load2  = 1'b0;
    load3  = 1'b0;
    enable = 1'b0;
    field  = FLD_NONE;
    unique case (r_state)
      IDLE:     enable = 1'b1;
      SET_HOUR: field  = FLD_HOUR;
      SET_MIN:  field  = FLD_MIN;
      SET_SEC:  field  = FLD_SEC;
      COMMIT_H: load3  = 1'b1;
      COMMIT_M: load2  = 1'b1;
      COMMIT_S: load1  = 1'b1;
      default:  enable = 1'b1;
    endcase
  end

  assign busy  = ~enable;
  assign data1 = r_sec;
  assign data2 = r_min;
  assign data3 = r_hour;

endmodule

// File: tb/tb_clock_setter.sv
// Directed-vector bench for clock_setter.
// Inputs change on the falling edge; outputs are checked there too.
module tb_clock_setter;

  logic       clock;
  logic       reset;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_dec;
  logic       btn_cancel;
  logic [5:0] cur_sec;
  logic [5:0] cur_min;
  logic [4:0] cur_hour;
  logic [5:0] data1;
  logic [5:0] data2;
  logic [5:0] data3;
  logic       load1;
  logic       load2;
  logic       load3;
  logic       enable;
  logic       busy;
  logic [1:0] field;

  int n_vec;
  int n_bad;

  clock_setter dut (
    .clock      (clock),
    .reset      (reset),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .btn_dec    (btn_dec),
    .btn_cancel (btn_cancel),
    .cur_sec    (cur_sec),
    .cur_min    (cur_min),
    .cur_hour   (cur_hour),
    .data1      (data1),
    .data2      (data2),
    .data3      (data3),
    .load1      (load1),
    .load2      (load2),
    .load3      (load3),
    .enable     (enable),
    .busy       (busy),
    .field      (field)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // apply one button combination for exactly one rising edge
  task automatic step(input logic m, input logic i,
                      input logic d, input logic c);
    btn_mode   = m;
    btn_inc    = i;
    btn_dec    = d;
    btn_cancel = c;
    @(negedge clock);
    btn_mode   = 1'b0;
    btn_inc    = 1'b0;
    btn_dec    = 1'b0;
    btn_cancel = 1'b0;
  endtask

  task automatic idle_cycle();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    cur_hour = 5'(h);
    cur_min  = 6'(m);
    cur_sec  = 6'(s);
  endtask

  int loads;

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b0;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    btn_cancel = 1'b0;
    set_cur(0, 0, 0);

    // reset held for two cycles
    @(negedge clock);
    @(negedge clock);
    check("rst_data1", data1, 0);
    check("rst_data2", data2, 0);
    check("rst_data3", data3, 0);
    check("rst_loads", {load3, load2, load1}, 0);
    check("rst_enable", enable, 1);
    check("rst_busy", busy, 0);
    check("rst_field", field, 0);
    reset = 1'b1;
    idle_cycle();
    check("post_rst_enable", enable, 1);
    check("post_rst_field", field, 0);

    // inc/dec/cancel ignored in IDLE
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("idle_ign_field", field, 0);
    check("idle_ign_enable", enable, 1);

    // main edit: 05:29:03 -> 07:28:03
    set_cur(5, 29, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("cap_field", field, 1);
    check("cap_hour", data3, 5);
    check("cap_min", data2, 29);
    check("cap_sec", data1, 3);
    check("edit_enable", enable, 0);
    check("edit_busy", busy, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("inc1_hour", data3, 6);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("inc2_hour", data3, 7);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("min_field", field, 2);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("dec_min", data2, 28);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("sec_field", field, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("ch_loads", {load3, load2, load1}, 3'b100);
    check("ch_data3", data3, 7);
    check("ch_enable", enable, 0);
    check("ch_field", field, 0);
    idle_cycle();
    check("cm_loads", {load3, load2, load1}, 3'b010);
    check("cm_data2", data2, 28);
    check("cm_enable", enable, 0);
    idle_cycle();
    check("cs_loads", {load3, load2, load1}, 3'b001);
    check("cs_data1", data1, 3);
    check("cs_enable", enable, 0);
    idle_cycle();
    check("done_loads", {load3, load2, load1}, 0);
    check("done_enable", enable, 1);
    check("done_busy", busy, 0);

    // wrap boundaries and simultaneous buttons
    set_cur(23, 0, 59);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("wrap_cap_hour", data3, 23);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("wrap_hour_up", data3, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("wrap_hour_dn", data3, 23);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("wrap_min_dn", data2, 59);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("wrap_min_up", data2, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("wrap_sec_up", data1, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("incdec_sec", data1, 0);
    check("incdec_field", field, 3);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("cancel_field", field, 0);
    check("cancel_enable", enable, 1);
    loads = 0;
    for (int k = 0; k < 4; k++) begin
      loads += int'(load1) + int'(load2) + int'(load3);
      idle_cycle();
    end
    check("cancel_noload", loads, 0);

    // mode beats inc in SET_HOUR
    set_cur(10, 20, 30);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("modeinc_field", field, 2);
    check("modeinc_hour", data3, 10);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("cancel_min", field, 0);

    // reset in COMMIT_M; buttons ignored in COMMIT_*
    set_cur(1, 2, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("rc_h_load3", load3, 1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("rc_m_load2", load2, 1);
    check("rc_m_data2", data2, 2);
    #2 reset = 1'b0;
    #1;
    check("rc_load2_drop", load2, 0);
    check("rc_enable", enable, 1);
    check("rc_data2", data2, 0);
    @(negedge clock);
    reset = 1'b1;
    loads = 0;
    for (int k = 0; k < 4; k++) begin
      loads += int'(load1) + int'(load2) + int'(load3);
      idle_cycle();
    end
    check("rc_no_load1", loads, 0);
    check("rc_enable_after", enable, 1);

    // out-of-range capture clamps to zero
    set_cur(30, 45, 62);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("clamp_hour", data3, 0);
    check("clamp_min", data2, 45);
    check("clamp_sec", data1, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("clamp_exit", field, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
